// File: rtl/fp_add_sequencer_if.sv
// Memory and adder bus between the fp_add_sequencer (master) and its environment (slave):
// instruction memory, data memory and the combinational double-precision adder.
interface fp_add_sequencer_if #(
   parameter int IAW = 6,
   parameter int DAW = 5
);
   logic                 imem_rd;
   logic [IAW-1:0]       imem_addr;
   logic [2+3*DAW-1:0]   imem_data;
   logic                 dmem_rd;
   logic                 dmem_we;
   logic [DAW-1:0]       dmem_addr;
   logic [63:0]          dmem_rdata;
   logic [63:0]          dmem_wdata;
   logic                 add_en;
   logic [63:0]          add_a;
   logic [63:0]          add_b;
   logic [63:0]          add_c;

   modport master (
      output imem_rd, imem_addr,
      input  imem_data,
      output dmem_rd, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata,
      output add_en, add_a, add_b,
      input  add_c
   );

   modport slave (
      input  imem_rd, imem_addr,
      output imem_data,
      input  dmem_rd, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata,
      input  add_en, add_a, add_b,
      output add_c
   );
endinterface

// File: rtl/fp_add_sequencer.sv
// Program sequencer for the 64-bit FP adder: fetch, read two operands, add/sub, write back.
// Zero-magnitude operands bypass the adder, which has no zero handling of its own.
module fp_add_sequencer #(
   parameter int IAW = 6,
   parameter int DAW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [IAW-1:0]  pc,
   output logic [15:0]     instr_count,
   fp_add_sequencer_if.master bus
);

   localparam int IW = 2 + 3*DAW;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_RDA    = 3'd3,
      ST_RDB    = 3'd4,
      ST_EXEC   = 3'd5,
      ST_WB     = 3'd6,
      ST_HALTED = 3'd7
   } state_t;

   state_t            state_r;
   logic [IW-1:0]     ir_r;
   logic [63:0]       opa_r;
   logic [63:0]       opb_r;
   logic [IAW-1:0]    pc_r;
   logic [15:0]       cnt_r;
   logic              busy_r;
   logic              done_r;
   logic              imem_rd_r;
   logic              dmem_rd_r;
   logic              dmem_we_r;
   logic              add_en_r;
   logic [DAW-1:0]    dmem_addr_r;
   logic [63:0]       wdata_s;
   logic              ir_srca_unused_s;

   function automatic logic mag_zero(input logic [63:0] v);
      return (v[62:0] == 63'd0);
   endfunction

   function automatic logic [1:0] f_op(input logic [IW-1:0] w);
      return w[IW-1 -: 2];
   endfunction

   function automatic logic [DAW-1:0] f_dst(input logic [IW-1:0] w);
      return w[3*DAW-1 -: DAW];
   endfunction

   function automatic logic [DAW-1:0] f_srca(input logic [IW-1:0] w);
      return w[2*DAW-1 -: DAW];
   endfunction

   function automatic logic [DAW-1:0] f_srcb(input logic [IW-1:0] w);
      return w[DAW-1:0];
   endfunction

   // srcA is issued straight from imem_data in DECODE, so the stored copy is never read back.
   assign ir_srca_unused_s = ^f_srca(ir_r);

   // Sequencer FSM; strobes and status are registered on entry to the state that owns them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ir_r        <= {IW{1'b0}};
         opa_r       <= 64'd0;
         opb_r       <= 64'd0;
         pc_r        <= {IAW{1'b0}};
         cnt_r       <= 16'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         imem_rd_r   <= 1'b0;
         dmem_rd_r   <= 1'b0;
         dmem_we_r   <= 1'b0;
         add_en_r    <= 1'b0;
         dmem_addr_r <= {DAW{1'b0}};
      end else begin
         imem_rd_r <= 1'b0;
         dmem_rd_r <= 1'b0;
         dmem_we_r <= 1'b0;
         add_en_r  <= 1'b0;
         case (state_r)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  pc_r      <= {IAW{1'b0}};
                  cnt_r     <= 16'd0;
                  state_r   <= ST_FETCH;
                  imem_rd_r <= 1'b1;
                  busy_r    <= 1'b1;
                  done_r    <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_FETCH: begin
               state_r <= ST_DECODE;
            end
            ST_DECODE: begin
               ir_r <= bus.imem_data;
               case (f_op(bus.imem_data))
                  OP_NOP: begin
                     pc_r      <= pc_r + IAW'(1);
                     cnt_r     <= cnt_r + 16'd1;
                     state_r   <= ST_FETCH;
                     imem_rd_r <= 1'b1;
                  end
                  OP_HALT: begin
                     state_r <= ST_HALTED;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     state_r     <= ST_RDA;
                     dmem_rd_r   <= 1'b1;
                     dmem_addr_r <= f_srca(bus.imem_data);
                  end
                  default: begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               endcase
            end
            ST_RDA: begin
               state_r     <= ST_RDB;
               dmem_rd_r   <= 1'b1;
               dmem_addr_r <= f_srcb(ir_r);
            end
            ST_RDB: begin
               opa_r   <= bus.dmem_rdata;
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               // SUB is an ADD with the second operand's sign flipped.
               opb_r       <= {bus.dmem_rdata[63] ^ (f_op(ir_r) == OP_SUB), bus.dmem_rdata[62:0]};
               state_r     <= ST_WB;
               dmem_we_r   <= 1'b1;
               add_en_r    <= 1'b1;
               dmem_addr_r <= f_dst(ir_r);
            end
            ST_WB: begin
               pc_r      <= pc_r + IAW'(1);
               cnt_r     <= cnt_r + 16'd1;
               state_r   <= ST_FETCH;
               imem_rd_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Write-back data: zero-magnitude operands bypass the adder; outside WB the bus is quiet.
   always_comb begin
      wdata_s = 64'd0;
      if (state_r == ST_WB) begin
         if (mag_zero(opa_r) && mag_zero(opb_r)) begin
            wdata_s = 64'd0;
         end else if (mag_zero(opa_r)) begin
            wdata_s = opb_r;
         end else if (mag_zero(opb_r)) begin
            wdata_s = opa_r;
         end else begin
            wdata_s = bus.add_c;
         end
      end else begin
         wdata_s = 64'd0;
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign pc             = pc_r;
   assign instr_count    = cnt_r;
   assign bus.imem_rd    = imem_rd_r;
   assign bus.imem_addr  = pc_r;
   assign bus.dmem_rd    = dmem_rd_r;
   assign bus.dmem_we    = dmem_we_r;
   assign bus.dmem_addr  = dmem_addr_r;
   assign bus.dmem_wdata = wdata_s;
   assign bus.add_en     = add_en_r;
   assign bus.add_a      = opa_r;
   assign bus.add_b      = opb_r;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer: a program-level reference model predicts every
// write-back and the final machine state; a negedge monitor checks writes as they appear.
module tb_fp_add_sequencer;

   localparam int IAW = 6;
   localparam int DAW = 5;

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
      logic [63:0] a;
      logic [63:0] b;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic [5:0]  pc;
   logic [15:0] instr_count;

   logic [16:0] imem [64];
   logic [63:0] dmem [32];
   logic [63:0] dmem_init [32];
   logic        load_req = 1'b0;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   fp_add_sequencer_if #(.IAW(IAW), .DAW(DAW)) bus ();

   fp_add_sequencer #(.IAW(IAW), .DAW(DAW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .pc(pc), .instr_count(instr_count), .bus(bus)
   );

   always #5 clk = ~clk;

   // Environment: synchronous-read memories and a behavioural double adder.
   always @(posedge clk) begin
      if (bus.imem_rd) bus.imem_data <= imem[bus.imem_addr];
      if (bus.dmem_rd) bus.dmem_rdata <= dmem[bus.dmem_addr];
      if (load_req) dmem <= dmem_init;
      else if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
   end

   assign bus.add_c = $realtobits($bitstoreal(bus.add_a) + $bitstoreal(bus.add_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the next predicted write-back.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && bus.dmem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write", bus.dmem_addr, bus.dmem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.dmem_addr), 64'(e.addr));
            chk("wr_data", bus.dmem_wdata, e.data);
            chk("wb_add_a", bus.add_a, e.a);
            chk("wb_add_b", bus.add_b, e.b);
            chk("wb_add_en", 64'(bus.add_en), 64'd1);
            chk("wb_no_rd", 64'(bus.dmem_rd), 64'd0);
         end
      end
   end

   function automatic logic [16:0] enc(input logic [1:0] op, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b);
      return {op, d, a, b};
   endfunction

   function automatic logic [63:0] rnd_val();
      int  r;
      real v;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 64'h0;
      if (r == 1) return 64'h8000000000000000;
      v = ($itor($urandom_range(0, 4000)) - 2000.0) / 16.0;
      return $realtobits(v);
   endfunction

   // Result of one ADD/SUB as the architecture defines it, working on real values.
   function automatic logic [63:0] fp_result(input logic [63:0] a, input logic [63:0] b);
      logic az, bz;
      az = (a[62:0] == 63'd0);
      bz = (b[62:0] == 63'd0);
      if (az && bz) return 64'h0;
      if (az) return b;
      if (bz) return a;
      return $realtobits($bitstoreal(a) + $bitstoreal(b));
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_pc"}, 64'(pc), 64'd0);
      chk({tag, "_cnt"}, 64'(instr_count), 64'd0);
      chk({tag, "_strobes"}, 64'({bus.imem_rd, bus.dmem_rd, bus.dmem_we, bus.add_en}), 64'd0);
      chk({tag, "_daddr"}, 64'(bus.dmem_addr), 64'd0);
      chk({tag, "_add_a"}, bus.add_a, 64'd0);
      chk({tag, "_add_b"}, bus.add_b, 64'd0);
      chk({tag, "_wdata"}, bus.dmem_wdata, 64'd0);
   endtask

   task automatic load_dmem();
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
      @(negedge clk);
   endtask

   // Run the loaded program to HALT; starts from a negedge, returns on a negedge.
   task automatic run_program(input int pulse_at);
      logic [63:0] m [32];
      logic [63:0] a, b, r;
      logic [16:0] w;
      wr_t         e;
      int          mpc, t, nret, n;
      bit          fin;
      load_dmem();
      m = dmem_init;
      mpc = 0; t = 0; nret = 0; fin = 0;
      while (!fin && mpc < 64) begin
         w = imem[mpc];
         if (w[16:15] == 2'b11) begin
            fin = 1;
         end else begin
            if (w[16:15] != 2'b00) begin
               a = m[w[9:5]];
               b = m[w[4:0]];
               if (w[16:15] == 2'b10) b[63] = ~b[63];
               r = fp_result(a, b);
               m[w[14:10]] = r;
               e.addr = w[14:10]; e.data = r; e.a = a; e.b = b;
               exp_q.push_back(e);
               t += 6;
            end else begin
               t += 2;
            end
            nret++;
            mpc++;
         end
      end
      start = 1'b1;
      n = 0;
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk);
         #1;
         n++;
         start = (n == pulse_at);
         if (n == 1) begin
            chk("fetch_busy", 64'(busy), 64'd1);
            chk("fetch_pc0", 64'(pc), 64'd0);
            chk("fetch_imem_rd", 64'(bus.imem_rd), 64'd1);
         end
         if (done) break;
      end
      start = 1'b0;
      chk("done_reached", 64'(done), 64'd1);
      chk("halt_cycles", 64'(n), 64'(t + 3));
      chk("halt_pc", 64'(pc), 64'(mpc));
      chk("halt_cnt", 64'(instr_count), 64'(nret));
      chk("halt_busy", 64'(busy), 64'd0);
      chk("pending_writes", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      for (int i = 0; i < 32; i++) chk("final_mem", dmem[i], m[i]);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 64; i++) imem[i] = enc(2'b11, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) dmem_init[i] = 64'd0;

      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      // Directed: ADD, SUB and zero bypass with a +0 operand.
      for (int i = 0; i < 32; i++) dmem_init[i] = rnd_val();
      dmem_init[0] = 64'h0;
      dmem_init[1] = 64'h3FF0000000000000;
      dmem_init[2] = 64'h4000000000000000;
      dmem_init[5] = 64'h4004000000000000;
      imem[0] = enc(2'b01, 5'd3, 5'd1, 5'd2);
      imem[1] = enc(2'b10, 5'd4, 5'd3, 5'd1);
      imem[2] = enc(2'b01, 5'd6, 5'd0, 5'd5);
      imem[3] = enc(2'b11, 5'd0, 5'd0, 5'd0);
      run_program(0);
      chk("dir_mem3", dmem[3], 64'h4008000000000000);
      chk("dir_mem4", dmem[4], 64'h4000000000000000);
      chk("dir_mem6", dmem[6], 64'h4004000000000000);

      // -0 minus -0 yields +0 through the bypass.
      dmem_init[5] = 64'h8000000000000000;
      dmem_init[7] = 64'h1111111111111111;
      imem[0] = enc(2'b10, 5'd7, 5'd5, 5'd5);
      imem[1] = enc(2'b11, 5'd0, 5'd0, 5'd0);
      run_program(0);
      chk("dir_mem7", dmem[7], 64'h0);

      // Randomized programs; every other run pulses start while busy.
      for (int it = 0; it < 8; it++) begin
         int len;
         len = int'($urandom_range(1, 12));
         for (int i = 0; i < 64; i++) imem[i] = enc(2'b11, 5'd0, 5'd0, 5'd0);
         for (int i = 0; i < len; i++)
            imem[i] = enc(2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         for (int i = 0; i < 32; i++) dmem_init[i] = rnd_val();
         run_program(((it % 2) == 1) ? 2 : 0);
      end

      // All-NOP program: pc wraps 63 -> 0, start while busy is ignored.
      for (int i = 0; i < 64; i++) imem[i] = enc(2'b00, 5'd0, 5'd0, 5'd0);
      start = 1'b1;
      for (int k = 1; k <= 140; k++) begin
         @(posedge clk);
         #1;
         start = (k == 40);
         chk("nop_pc", 64'(pc), 64'(((k - 1) / 2) % 64));
         chk("nop_cnt", 64'(instr_count), 64'((k - 1) / 2));
         chk("nop_busy", 64'(busy), 64'd1);
      end
      start = 1'b0;
      rst = 1'b1;
      #1 check_all_zero("rst_nop");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset during EXEC abandons the write.
      for (int i = 0; i < 32; i++) dmem_init[i] = rnd_val();
      dmem_init[1] = 64'h3FF0000000000000;
      dmem_init[2] = 64'h4000000000000000;
      dmem_init[3] = 64'h0000000000001234;
      for (int i = 0; i < 64; i++) imem[i] = enc(2'b11, 5'd0, 5'd0, 5'd0);
      imem[0] = enc(2'b01, 5'd3, 5'd1, 5'd2);
      load_dmem();
      start = 1'b1;
      n = 0;
      repeat (5) begin
         @(posedge clk);
         #1 start = 1'b0;
         n++;
      end
      chk("exec_cycle_no_we", 64'(bus.dmem_we), 64'd0);
      rst = 1'b1;
      #1 check_all_zero("rst_exec");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_exec_mem3", dmem[3], 64'h0000000000001234);
      chk("rst_exec_idle", 64'({busy, done}), 64'd0);
      run_program(0);
      chk("restart_mem3", dmem[3], 64'h4008000000000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Program sequencer for the 64-bit floating-point adder. It fetches instructions from instruction memory and reads two IEEE-754 double operands from data memory. It drives the combinational `addition` datapath and writes the result back to data memory. It handles signed-zero operands itself, because the adder datapath has no zero handling, and it stops on a HALT instruction.

## Interface
Parameters:
- IAW, 6, instruction-memory address width
- DAW, 5, data-memory address width

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins execution at pc 0; honoured only in IDLE or HALTED
- busy  output  1  high in every state except IDLE and HALTED
- done  output  1  high while in HALTED
- imem_rd  output  1  instruction read strobe
- imem_addr  output  IAW  instruction address, equal to pc
- imem_data  input  2+3*DAW  instruction word: [3*DAW+1:3*DAW] opcode, then dst, srcA, srcB (srcB in LSBs)
- dmem_rd  output  1  data read strobe
- dmem_we  output  1  data write strobe
- dmem_addr  output  DAW  data address
- dmem_rdata  input  64  read data
- dmem_wdata  output  64  write data
- add_en  output  1  adder enable
- add_a, add_b  output  64  adder operands
- add_c  input  64  adder result (combinational)
- pc  output  IAW  program counter
- instr_count  output  16  number of retired instructions

## Operation
- Opcodes:
  - 00 NOP
  - 01 ADD: mem[dst] = mem[srcA] + mem[srcB]
  - 10 SUB: mem[dst] = mem[srcA] − mem[srcB]
  - 11 HALT
- Both memories are synchronous-read: data is valid in the cycle after the strobe.
- States: IDLE, FETCH, DECODE, RDA, RDB, EXEC, WB, HALTED.
- IDLE / HALTED:
  - start=1 clears pc and instr_count, then goes to FETCH.
  - Otherwise the block stays in the current state.
- FETCH: imem_rd=1, imem_addr=pc. Goes to DECODE.
- DECODE:
  - Captures imem_data into the instruction register.
  - NOP: pc+1, instr_count+1, go to FETCH.
  - HALT: go to HALTED; pc and instr_count are unchanged.
  - ADD/SUB: go to RDA.
- RDA: dmem_rd=1, dmem_addr=srcA. Goes to RDB.
- RDB: dmem_rd=1, dmem_addr=srcB; captures dmem_rdata into opa. Goes to EXEC.
- EXEC: captures dmem_rdata into opb, inverting bit 63 when the opcode is SUB. Goes to WB.
- WB:
  - add_en=1, dmem_we=1, dmem_addr=dst.
  - pc+1, instr_count+1; go to FETCH.
  - dmem_wdata is selected as follows:
    - opa[62:0]==0 and opb[62:0]==0: 64'h0
    - only opa[62:0]==0: opb
    - only opb[62:0]==0: opa
    - otherwise: add_c
- add_a and add_b always reflect the opa/opb registers. add_en is high only in WB.
- pc wraps from 2^IAW−1 to 0 and execution continues. instr_count wraps from 16'hFFFF to 0.
- dst may equal srcA or srcB: the read completes before the write.
- start while busy is ignored.

## Timing
- All outputs reset to 0 and the state resets to IDLE: busy, done, strobes, addresses, pc, instr_count, add_a, add_b, dmem_wdata.
- ADD/SUB take 6 cycles (FETCH to WB). NOP takes 2 cycles. HALT reaches HALTED 2 cycles after FETCH.
- In the start cycle the block moves to FETCH on the next edge. busy rises one cycle after start is sampled.
- Strobes are single-cycle. At most one of dmem_rd and dmem_we is high in any cycle.
- rst asserted in any state forces IDLE immediately; any pending write is abandoned (dmem_we=0).
- Operand registers hold their values until overwritten, so the adder inputs are stable through WB.

## Test plan
- mem[1]=3FF0000000000000, mem[2]=4000000000000000; program ADD 3,1,2 then HALT → mem[3]=4008000000000000 written in cycle 6; done high 2 cycles later; instr_count=1.
- SUB 4,3,1 with mem[3]=4008000000000000, mem[1]=3FF0000000000000 → add_b=BFF0000000000000 in WB; mem[4]=4000000000000000.
- Zero bypass:
  - mem[0]=0, mem[5]=4004000000000000; ADD 6,0,5 → mem[6]=4004000000000000.
  - SUB 7,5,5 with mem[5]=8000000000000000 → mem[7]=0.
- IAW=2 program NOP,NOP,NOP,NOP looping: pc sequence 0,1,2,3,0; instr_count increments every 2 cycles; busy stays high.
- Assert rst during EXEC of an ADD → dmem_we never pulses, all outputs 0, state IDLE; then start → execution restarts at pc 0.
- Pulse start while busy → pc and instr_count are not cleared. Pulse start in HALTED → execution restarts at pc 0.
